dm_arbiter: RTL and testbench



---
 rtl/dm_arbiter_if.sv | 42 ++++
 rtl/dm_arbiter.sv | 135 +++++++++++++
 tb/tb_dm_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_arbiter_if.sv
// Bundle for the data-memory arbiter: per-core request side plus shared DM port.
// The lock vector is present only when DM_ARB_LOCK_EN is defined.
interface dm_arbiter_if #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
);
  logic [N_CORES-1:0]        req;
  logic [N_CORES-1:0]        we;
  logic [N_CORES*ADDR_W-1:0] addr;
  logic [N_CORES*DATA_W-1:0] wdata;
  logic [N_CORES-1:0]        gnt;
  logic [N_CORES-1:0]        done;
  logic [DATA_W-1:0]         rdata;
  logic                      mem_en;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;
`ifdef DM_ARB_LOCK_EN
  logic [N_CORES-1:0]        lock;
`endif

  // Handshake: req is a level sampled only while the arbiter is idle; gnt is a
  // one-cycle pulse marking the DM access cycle, done a one-cycle pulse marking
  // completion (rdata valid with it for reads). One access outstanding at a time.
  modport slave (
`ifdef DM_ARB_LOCK_EN
    input  lock,
`endif
    input  req, we, addr, wdata, mem_rdata,
    output gnt, done, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
`ifdef DM_ARB_LOCK_EN
    output lock,
`endif
    output req, we, addr, wdata, mem_rdata,
    input  gnt, done, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one data-memory port among N_CORES cores.
// Optional DM_ARB_LOCK_EN: lock[owner] keeps arbitration on the owner for atomic RMW.
module dm_arbiter #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic        clk,
  input  logic        rstn,
  dm_arbiter_if.slave bus,
  output logic [1:0]  dbg_state
);
  localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam logic [N_CORES-1:0] ONE = N_CORES'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RDWAIT = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d, owner_q, owner_d, win;
  logic [N_CORES-1:0]  gnt_q, gnt_d, done_q, done_d, cand;
  logic                mem_en_q, mem_en_d, mem_we_q, mem_we_d, found;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
  int                  idx;
`ifdef DM_ARB_LOCK_EN
  logic                owner_ok_q, owner_ok_d;
`endif

  // Winner search starts just after the last winner and wraps around.
  always_comb begin
    cand  = bus.req;
`ifdef DM_ARB_LOCK_EN
    if (owner_ok_q && bus.lock[owner_q]) cand = bus.req & (ONE << owner_q);
`endif
    found = 1'b0;
    win   = ptr_q;
    idx   = 0;
    for (int k = 1; k <= N_CORES; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_CORES) idx = idx - N_CORES;
      if (!found && cand[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    gnt_d       = '0;
    done_d      = '0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
`ifdef DM_ARB_LOCK_EN
    owner_ok_d  = owner_ok_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = ACCESS;
          gnt_d       = ONE << win;
          mem_en_d    = 1'b1;
          mem_we_d    = bus.we[win];
          mem_addr_d  = bus.addr[win*ADDR_W +: ADDR_W];
          mem_wdata_d = bus.wdata[win*DATA_W +: DATA_W];
          ptr_d       = win;
          owner_d     = win;
`ifdef DM_ARB_LOCK_EN
          owner_ok_d  = 1'b1;
`endif
        end
      end
      ACCESS: begin
        if (mem_we_q) begin
          state_d = IDLE;
          done_d  = ONE << owner_q;
        end else begin
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        rdata_d = bus.mem_rdata;
        done_d  = ONE << owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      ptr_q       <= PW'(N_CORES - 1);
      owner_q     <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
`ifdef DM_ARB_LOCK_EN
      owner_ok_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
`ifdef DM_ARB_LOCK_EN
      owner_ok_q  <= owner_ok_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: transaction-level round-robin model,
// shadow memory for read data, and a synchronous DM model on the shared port.
module tb_dm_arbiter;
  localparam int N = 4;
  localparam int A = 16;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [1:0] dbg_state;
  logic [N-1:0] lock_v = '0;
  int total = 0;
  int bad = 0;
  int m_ptr = N - 1;
  bit m_owner_ok = 1'b0;
  logic [D-1:0] exp_q[$];
  logic [D-1:0] ref_mem [256];
  logic [D-1:0] dm [256];

  dm_arbiter_if #(.N_CORES(N), .ADDR_W(A), .DATA_W(D)) bus ();

  dm_arbiter #(.N_CORES(N), .ADDR_W(A), .DATA_W(D)) dut (
    .clk(clk), .rstn(rstn), .bus(bus.slave), .dbg_state(dbg_state)
  );

`ifdef DM_ARB_LOCK_EN
  assign bus.lock = lock_v;
`endif

  always #5 clk = ~clk;

  // Data memory: synchronous read, write on the access cycle.
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) dm[bus.mem_addr[7:0]] <= bus.mem_wdata;
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= dm[bus.mem_addr[7:0]];
  end

  always @(negedge clk) begin
    if (rstn) begin
      total++;
      if ((bus.gnt != '0 && bus.done != '0) || !$onehot0(bus.gnt) || !$onehot0(bus.done)) begin
        bad++;
        $display("FAIL pulse_excl: gnt=%b done=%b required one-hot-or-zero and not both", bus.gnt, bus.done);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    m_ptr = N - 1;
    m_owner_ok = 1'b0;
  endtask

  // One arbitration from idle: predict winner, check grant, access and completion.
  task automatic run_txn(input logic [N-1:0] reqs);
    logic [N-1:0] cand, oh;
    logic [A-1:0] a;
    logic [D-1:0] d, exp_rd;
    logic wr;
    int w;
    cand = reqs;
    if (m_owner_ok && lock_v[m_ptr]) cand = reqs & (N'(1) << m_ptr);
    w = -1;
    for (int k = 1; k <= N; k++)
      if (w < 0 && cand[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    if (w < 0) begin
      $display("FAIL run_txn: no eligible requester in stimulus");
      bad++;
      return;
    end
    oh = N'(1) << w;
    a = bus.addr[w*A +: A];
    d = bus.wdata[w*D +: D];
    wr = bus.we[w];
    bus.req = reqs;
    @(negedge clk);
    bus.req = '0;
    total++;
    if ({bus.gnt, bus.done, bus.mem_en, bus.mem_we, bus.mem_addr} !== {oh, {N{1'b0}}, 1'b1, wr, a}) begin
      bad++;
      $display("FAIL grant: gnt/done/en/we/addr=%b/%b/%b/%b/%h required %b/%b/1/%b/%h",
               bus.gnt, bus.done, bus.mem_en, bus.mem_we, bus.mem_addr, oh, {N{1'b0}}, wr, a);
    end
    m_ptr = w;
    m_owner_ok = 1'b1;
    if (wr) begin
      total++;
      if (bus.mem_wdata !== d) begin
        bad++;
        $display("FAIL mem_wdata: got %h required %h", bus.mem_wdata, d);
      end
      ref_mem[a[7:0]] = d;
      @(negedge clk);
      total++;
      if ({bus.gnt, bus.done, bus.mem_en, bus.mem_we} !== {{N{1'b0}}, oh, 2'b00}) begin
        bad++;
        $display("FAIL wr_done: gnt=%b done=%b en=%b we=%b required done=%b", bus.gnt, bus.done, bus.mem_en, bus.mem_we, oh);
      end
    end else begin
      exp_q.push_back(ref_mem[a[7:0]]);
      @(negedge clk);
      total++;
      if ({bus.gnt, bus.done, bus.mem_en} !== {{N{1'b0}}, {N{1'b0}}, 1'b0}) begin
        bad++;
        $display("FAIL rd_wait: gnt=%b done=%b en=%b required all zero", bus.gnt, bus.done, bus.mem_en);
      end
      @(negedge clk);
      exp_rd = exp_q.pop_front();
      total++;
      if ({bus.done, bus.rdata} !== {oh, exp_rd}) begin
        bad++;
        $display("FAIL rd_done: done=%b rdata=%h required done=%b rdata=%h", bus.done, bus.rdata, oh, exp_rd);
      end
    end
  endtask

  task automatic set_core(input int c, input logic w, input logic [A-1:0] a, input logic [D-1:0] d);
    bus.we[c] = w;
    bus.addr[c*A +: A] = a;
    bus.wdata[c*D +: D] = d;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({bus.gnt, bus.done, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.rdata} !== '0) begin
        bad++;
        $display("FAIL reset_idle: gnt=%b done=%b en=%b we=%b addr=%h wd=%h rd=%h required all zero",
                 bus.gnt, bus.done, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.rdata);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_write_read();
    set_core(2, 1'b1, 16'h0040, 16'hBEEF);
    run_txn(4'b0100);
    set_core(1, 1'b0, 16'h0040, 16'h0000);
    run_txn(4'b0010);
  endtask

  task automatic test_wrap();
    set_core(3, 1'b1, 16'h0011, 16'h1234);
    set_core(0, 1'b1, 16'h0012, 16'h5678);
    run_txn(4'b1000);
    run_txn(4'b1001);
    run_txn(4'b1001);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      for (int c = 0; c < N; c++)
        set_core(c, 1'($urandom_range(0, 1)), A'($urandom_range(0, 15)), D'($urandom_range(0, 16'hFFFF)));
      run_txn(N'($urandom_range(1, (1 << N) - 1)));
    end
  endtask

  task automatic test_all_reads();
    logic [N-1:0] oh;
    logic [D-1:0] exp_rd;
    int w;
    for (int c = 0; c < N; c++) set_core(c, 1'b0, A'(c + 2), '0);
    do_reset();
    bus.req = '1;
    for (int g = 0; g < 5; g++) begin
      w = (m_ptr + 1) % N;
      oh = N'(1) << w;
      exp_q.push_back(ref_mem[w + 2]);
      @(negedge clk);
      total++;
      if ({bus.gnt, bus.mem_en} !== {oh, 1'b1}) begin
        bad++;
        $display("FAIL all_gnt%0d: gnt=%b en=%b required gnt=%b en=1", g, bus.gnt, bus.mem_en, oh);
      end
      m_ptr = w;
      @(negedge clk);
      @(negedge clk);
      exp_rd = exp_q.pop_front();
      total++;
      if ({bus.done, bus.rdata} !== {oh, exp_rd}) begin
        bad++;
        $display("FAIL all_done%0d: done=%b rdata=%h required %b %h", g, bus.done, bus.rdata, oh, exp_rd);
      end
      if (g == 4) bus.req = '0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    set_core(1, 1'b0, 16'h0040, '0);
    bus.req = 4'b0010;
    @(negedge clk);
    bus.req = '0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    total++;
    if ({bus.gnt, bus.done, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.rdata} !== '0) begin
      bad++;
      $display("FAIL reset_mid: gnt=%b done=%b en=%b addr=%h rd=%h required all zero",
               bus.gnt, bus.done, bus.mem_en, bus.mem_addr, bus.rdata);
    end
    repeat (2) begin
      @(negedge clk);
      total++;
      if (bus.done !== '0) begin
        bad++;
        $display("FAIL reset_no_done: done=%b required 0", bus.done);
      end
    end
    rstn = 1'b1;
    m_ptr = N - 1;
    m_owner_ok = 1'b0;
    for (int c = 0; c < N; c++) set_core(c, 1'b0, A'(c + 8), '0);
    run_txn(4'b1111);
  endtask

`ifdef DM_ARB_LOCK_EN
  task automatic test_lock();
    set_core(2, 1'b0, 16'h0040, '0);
    set_core(0, 1'b1, 16'h0041, 16'hA5A5);
    lock_v = 4'b0100;
    run_txn(4'b0100);
    run_txn(4'b0101);
    bus.req = 4'b0001;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (bus.gnt !== '0) begin
        bad++;
        $display("FAIL lock_hold: gnt=%b required 0", bus.gnt);
      end
    end
    lock_v = '0;
    run_txn(4'b0001);
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = '0;
      dm[i] = '0;
    end
    bus.req = '0;
    bus.we = '0;
    bus.addr = '0;
    bus.wdata = '0;
    bus.mem_rdata = '0;
    test_reset();
    test_write_read();
    test_wrap();
    test_random();
    test_all_reads();
    test_reset_mid();
`ifdef DM_ARB_LOCK_EN
    test_lock();
`endif
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
